// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: default widths, saturation bounds
// and the sign-magnitude to two's-complement helper.
package nn_pkg;

   localparam int NN_WIDTH_DEFAULT     = 8;
   localparam int NN_ACC_WIDTH_DEFAULT = 16;
   localparam int NN_SAT_MAX_DEFAULT   = (1 << (NN_ACC_WIDTH_DEFAULT - 1)) - 1;
   localparam int NN_SAT_MIN_DEFAULT   = -(1 << (NN_ACC_WIDTH_DEFAULT - 1));
   localparam int NN_TWOS_W            = 64;

   // Only the low 'width' bits of mag are significant; a zero magnitude gives +0.
   function automatic logic signed [NN_TWOS_W-1:0] to_twos(input logic sign,
                                                           input logic [NN_TWOS_W-1:0] mag,
                                                           input int width);
      logic [NN_TWOS_W-1:0] m;
      m = mag & ((64'd1 << width) - 64'd1);
      return sign ? -$signed(m) : $signed(m);
   endfunction

endpackage

// File: rtl/sm_mult_pipe.sv
// Pipelined sign-magnitude multiplier; valid, last and first travel beside the
// product so consecutive vectors stay separated through the pipe.
module sm_mult_pipe import nn_pkg::*; #(
   parameter int WIDTH  = NN_WIDTH_DEFAULT,
   parameter int STAGES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic                 in_first,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     w,
   output logic                 out_valid,
   output logic                 out_last,
   output logic                 out_first,
   output logic                 out_sign,
   output logic [2*WIDTH-3:0]   out_mag,
   output logic                 busy
);

   localparam int MW = 2 * WIDTH - 2;

   logic [MW-1:0]     mag_in;
   logic              sign_in;
   logic [STAGES-1:0] vld_p;
   logic [STAGES-1:0] last_p;
   logic [STAGES-1:0] first_p;
   logic [STAGES-1:0] sign_p;
   logic [MW-1:0]     mag_p [STAGES];

   always_comb begin
      mag_in  = MW'(a[WIDTH-2:0]) * MW'(w[WIDTH-2:0]);
      sign_in = (a[WIDTH-1] ^ w[WIDTH-1]) & (mag_in != '0);
   end

   // stage 0 captures the product; later stages are pure delay
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_valid;
         for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      last_p[0]  <= in_last;
      first_p[0] <= in_first;
      sign_p[0]  <= sign_in;
      mag_p[0]   <= mag_in;
      for (int i = 1; i < STAGES; i++) begin
         last_p[i]  <= last_p[i-1];
         first_p[i] <= first_p[i-1];
         sign_p[i]  <= sign_p[i-1];
         mag_p[i]   <= mag_p[i-1];
      end
   end

   assign out_valid = vld_p[STAGES-1];
   assign out_last  = last_p[STAGES-1];
   assign out_first = first_p[STAGES-1];
   assign out_sign  = sign_p[STAGES-1];
   assign out_mag   = mag_p[STAGES-1];
   assign busy      = |vld_p;

endmodule

// File: rtl/nn_mac_pipe.sv
// Neuron MAC: pipelined sign-magnitude products accumulated per vector with
// clamping and a sticky overflow flag reported alongside the final sum.
module nn_mac_pipe import nn_pkg::*; #(
   parameter int WIDTH     = NN_WIDTH_DEFAULT,
   parameter int STAGES    = 4,
   parameter int ACC_WIDTH = NN_ACC_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     w,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_ovf,
   output logic                 busy
);

   localparam int MW = 2 * WIDTH - 2;
   localparam int SW = ACC_WIDTH + 1;
   localparam logic signed [SW-1:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

   logic                        first_in;
   logic                        m_vld, m_last, m_first, m_sign, m_busy;
   logic [MW-1:0]               m_mag;
   logic signed [ACC_WIDTH-1:0] acc;
   logic                        ovf, in_vec;
   logic signed [SW-1:0]        prod_ext, sum_raw;
   logic signed [ACC_WIDTH-1:0] sum_sat;
   logic                        ovf_nxt;

   function automatic logic is_clamped(input logic signed [SW-1:0] x);
      return (x > SAT_MAX) || (x < SAT_MIN);
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic signed [SW-1:0] x);
      if (x > SAT_MAX) return SAT_MAX[ACC_WIDTH-1:0];
      if (x < SAT_MIN) return SAT_MIN[ACC_WIDTH-1:0];
      return x[ACC_WIDTH-1:0];
   endfunction

   // the beat after reset or after an in_last beat opens a new vector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        first_in <= 1'b1;
      else if (in_valid) first_in <= in_last;
   end

   sm_mult_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) u_mult (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_first  (first_in),
      .a         (a),
      .w         (w),
      .out_valid (m_vld),
      .out_last  (m_last),
      .out_first (m_first),
      .out_sign  (m_sign),
      .out_mag   (m_mag),
      .busy      (m_busy)
   );

   always_comb begin
      prod_ext = SW'(to_twos(m_sign, NN_TWOS_W'(m_mag), MW));
      sum_raw  = m_first ? prod_ext : $signed({acc[ACC_WIDTH-1], acc}) + prod_ext;
      sum_sat  = saturate(sum_raw);
      ovf_nxt  = (m_first ? 1'b0 : ovf) | is_clamped(sum_raw);
   end

   // accumulator stage; the last beat hands its result to the output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc       <= '0;
         ovf       <= 1'b0;
         in_vec    <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= m_vld & m_last;
         if (m_vld) begin
            if (m_last) begin
               out_sum <= sum_sat;
               out_ovf <= ovf_nxt;
               acc     <= '0;
               ovf     <= 1'b0;
               in_vec  <= 1'b0;
            end else begin
               acc     <= sum_sat;
               ovf     <= ovf_nxt;
               in_vec  <= 1'b1;
            end
         end
      end
   end

   assign busy = m_busy | in_vec | out_valid;

endmodule

// File: tb/tb_nn_mac_pipe.sv
// Scoreboard bench for nn_mac_pipe: a behavioural integer model queues the
// expected sum, overflow flag and arrival cycle for every vector.
module tb_nn_mac_pipe;
   import nn_pkg::*;

   localparam int WIDTH     = 8;
   localparam int STAGES    = 4;
   localparam int ACC_WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_last = 1'b0;
   logic [WIDTH-1:0]     a = '0;
   logic [WIDTH-1:0]     w = '0;
   logic                 out_valid;
   logic [ACC_WIDTH-1:0] out_sum;
   logic                 out_ovf;
   logic                 busy;

   typedef struct {
      logic [ACC_WIDTH-1:0] sum;
      logic                 ovf;
      int                   cyc;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    n_out = 0;
   int    m_acc = 0;
   logic  m_ovf = 1'b0;
   logic  m_first = 1'b1;
   string tname = "reset";

   nn_mac_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .ACC_WIDTH(ACC_WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .a         (a),
      .w         (w),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         n_out++;
         if (sb.size() == 0) begin
            chk({tname, "_unexpected_valid"}, 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({tname, "_sum"}, 32'(out_sum), 32'(e.sum));
            chk({tname, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
            chk({tname, "_latency"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic beat(input logic [7:0] aa, input logic [7:0] ww, input logic last);
      int   p, s;
      logic clamp;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_last  = last;
      a        = aa;
      w        = ww;
      p = int'(aa[6:0]) * int'(ww[6:0]);
      if (aa[7] ^ ww[7]) p = -p;
      s = m_first ? p : m_acc + p;
      clamp = 1'b0;
      if (s > NN_SAT_MAX_DEFAULT) begin s = NN_SAT_MAX_DEFAULT; clamp = 1'b1; end
      if (s < NN_SAT_MIN_DEFAULT) begin s = NN_SAT_MIN_DEFAULT; clamp = 1'b1; end
      m_ovf   = (m_first ? 1'b0 : m_ovf) | clamp;
      m_acc   = s;
      m_first = last;
      if (last) begin
         e.sum = 16'(s);
         e.ovf = m_ovf;
         e.cyc = cyc + STAGES + 1;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         a        = 8'($urandom_range(0, 255));
         w        = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic drain();
      int i;
      idle(1);
      for (i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
      #1;
      chk({tname, "_drain"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int n0;
      logic last;
      int len;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum",   32'(out_sum),   32'd0);
      chk("rst_out_ovf",   32'(out_ovf),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      reset = 1'b1;

      tname = "single";
      beat(8'h03, 8'h85, 1'b1);
      idle(1);
      chk("single_busy_inflight", 32'(busy), 32'd1);
      drain();
      idle(2);
      chk("single_hold_sum", 32'(out_sum), 32'h0000FFF1);
      chk("single_hold_ovf", 32'(out_ovf), 32'd0);
      chk("single_busy_idle", 32'(busy), 32'd0);

      tname = "negzero";
      beat(8'h80, 8'h05, 1'b1);
      drain();
      chk("negzero_hold_sum", 32'(out_sum), 32'd0);

      tname = "sat_pos";
      for (int i = 0; i < 4; i++) beat(8'h7F, 8'h7F, i == 3);
      drain();
      chk("sat_pos_hold", 32'({out_ovf, out_sum}), 32'h00017FFF);

      tname = "sat_neg";
      for (int i = 0; i < 4; i++) beat(8'h7F, 8'hFF, i == 3);
      drain();
      chk("sat_neg_hold", 32'({out_ovf, out_sum}), 32'h00018000);

      tname = "b2b";
      beat(8'h02, 8'h03, 1'b0);
      beat(8'h04, 8'h05, 1'b1);
      beat(8'h81, 8'h07, 1'b1);
      drain();
      chk("b2b_hold_sum", 32'(out_sum), 32'h0000FFF9);

      tname = "bubbles";
      n0 = n_out;
      beat(8'h01, 8'h01, 1'b0);
      idle(2);
      beat(8'h01, 8'h01, 1'b1);
      drain();
      idle(3);
      chk("bubbles_pulse_count", 32'(n_out - n0), 32'd1);
      chk("bubbles_hold_sum", 32'(out_sum), 32'd2);

      tname = "midreset";
      n0 = n_out;
      beat(8'h05, 8'h05, 1'b0);
      beat(8'h03, 8'h02, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      a        = 8'h04;
      w        = 8'h04;
      reset    = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_out_sum",   32'(out_sum),   32'd0);
      chk("midreset_out_ovf",   32'(out_ovf),   32'd0);
      chk("midreset_busy",      32'(busy),      32'd0);
      idle(2);
      reset   = 1'b1;
      m_first = 1'b1;
      m_acc   = 0;
      m_ovf   = 1'b0;
      idle(10);
      chk("midreset_no_pulse", 32'(n_out - n0), 32'd0);
      beat(8'h06, 8'h06, 1'b1);
      drain();
      chk("midreset_after_sum", 32'(out_sum), 32'd36);

      tname = "random";
      for (int v = 0; v < 10; v++) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            last = (b == len - 1);
            beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), last);
         end
      end
      drain();
      idle(3);
      chk("final_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
